// File: rtl/pc_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ram_pkg
//  Brief    : Shared types and constants for the pc_ram arbiter slice.
//  Revision : 1.0  initial release
// ============================================================================
package pc_ram_pkg;

    // Arbiter top-level state: clearing the RAM, or serving requesters.
    typedef enum logic {ST_INIT, ST_RUN} arb_state_t;

    // Requester indices into the req/gnt vectors.
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

endpackage
`default_nettype wire

// File: rtl/pc_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ram_arbiter_if
//  Brief    : Requester A/B command+response signals and the RAM-side bus
//             of the pc_ram arbiter, bundled with master/slave views.
//  Revision : 1.0  initial release
// ============================================================================
interface pc_ram_arbiter_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 10
);
    // Requester A
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;
    // Requester B
    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;
    // RAM side
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;
    // Status
    logic                  init_done;

    // Requesters and the RAM, seen from outside the arbiter.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_addr, ram_data, ram_we,
        output ram_q,
        input  init_done
    );

    // The arbiter itself.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_addr, ram_data, ram_we,
        input  ram_q,
        output init_done
    );
endinterface
`default_nettype wire

// File: rtl/pc_ram_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Brief    : Two-way round-robin arbiter. On contention the port that did
//             not win last is chosen; grants only issue while advance is high.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import pc_ram_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req,
    input  wire logic       advance,
    output logic      [1:0] gnt
);

    logic       r_last_grant;   // index of the most recent winner
    logic [1:0] w_pick;

    // Pick a winner: lone requester wins, contention goes to the non-last port.
    always_comb begin
        w_pick = '0;
        case (req)
            2'b01:   w_pick = 2'b01;
            2'b10:   w_pick = 2'b10;
            2'b11:   w_pick = (r_last_grant == 1'(PORT_B)) ? 2'b01 : 2'b10;
            default: w_pick = '0;
        endcase
        gnt = advance ? w_pick : 2'b00;
    end

    // Remember the winner; idle cycles leave the history untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'(PORT_B);
        end else if (|gnt) begin
            r_last_grant <= gnt[PORT_B];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ram_arbiter
//  Brief    : Shares one single-port synchronous RAM between requesters A
//             and B with round-robin arbitration, after an optional
//             post-reset sweep that writes INIT_VAL to every word.
//  Revision : 1.0  initial release
// ============================================================================
module pc_ram_arbiter
    import pc_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 1,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL       = '0
) (
    input wire logic          clk,
    input wire logic          rst,
    pc_ram_arbiter_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR   = '1;
    localparam arb_state_t            C_RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
    logic                  r_init_done;
    logic                  r_a_rd_pend;
    logic                  r_b_rd_pend;
    logic [ADDR_WIDTH-1:0] r_addr_hold;     // last address put on the RAM bus
    logic                  w_advance;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_data;
    logic                  w_ram_we;

    // Requests are only arbitrated in RUN and never while reset is held,
    // so requests raised during the sweep simply wait.
    assign w_advance         = !rst && (r_state == ST_RUN);
    assign w_req[PORT_A]     = bus.a_req;
    assign w_req[PORT_B]     = bus.b_req;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_advance),
        .gnt     (w_gnt)
    );

    // Next-state logic: the sweep walks every address once, then RUN forever.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_INIT: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == C_LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = C_RESET_STATE;
        endcase
    end

    // RAM command mux: sweep write, else the winner's command, else a
    // harmless idle that re-presents the previous address.
    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_addr = r_addr_hold;
        w_ram_data = '0;
        if (!rst && (r_state == ST_INIT)) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_clr_cnt;
            w_ram_data = INIT_VAL;
        end else if (w_gnt[PORT_A]) begin
            w_ram_we   = bus.a_we;
            w_ram_addr = bus.a_addr;
            w_ram_data = bus.a_wdata;
        end else if (w_gnt[PORT_B]) begin
            w_ram_we   = bus.b_we;
            w_ram_addr = bus.b_addr;
            w_ram_data = bus.b_wdata;
        end
    end

    // State, sweep counter, read-pending flags and the idle address hold.
    // init_done tracks the registered state, so it rises together with RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= C_RESET_STATE;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
            r_a_rd_pend <= 1'b0;
            r_b_rd_pend <= 1'b0;
            r_addr_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
            r_a_rd_pend <= w_gnt[PORT_A] && !bus.a_we;
            r_b_rd_pend <= w_gnt[PORT_B] && !bus.b_we;
            r_addr_hold <= w_ram_addr;
        end
    end

    assign bus.a_gnt     = w_gnt[PORT_A];
    assign bus.b_gnt     = w_gnt[PORT_B];
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_data  = w_ram_data;
    assign bus.init_done = r_init_done;
    // The RAM returns the word one cycle after the address, which is exactly
    // when the pending flag matures, so read data is a straight pass-through.
    assign bus.a_rvalid  = r_a_rd_pend;
    assign bus.b_rvalid  = r_b_rd_pend;
    assign bus.a_rdata   = bus.ram_q;
    assign bus.b_rdata   = bus.ram_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_ram_arbiter
//  Brief    : Self-checking bench for pc_ram_arbiter with a RAM model and a
//             cycle-level reference of arbitration, sweep and read returns.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_ram_arbiter;

    localparam int         DW    = 8;
    localparam int         AW    = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] IV    = 8'h3C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pc_ram_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1),
        .INIT_VAL       (IV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port synchronous RAM: registered read address, write on edge.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [AW-1:0] ram_raddr;
    always_ff @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_data;
        ram_raddr <= bus.ram_addr;
    end
    assign bus.ram_q = ram_mem[ram_raddr];

    // ---------------- reference model state ----------------
    int        total = 0;
    int        bad   = 0;
    bit        m_run;
    int        m_cnt;
    int        m_last;           // 0 = A won last, 1 = B won last
    logic [7:0] m_mem [DEPTH];
    bit        m_pa, m_pb;       // read response due this cycle
    logic [7:0] m_da, m_db;
    int        m_hold;
    bit        m_ga, m_gb;       // grants expected in the cycle just finished

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_a(input bit req, input bit we, input int addr, input logic [7:0] d);
        bus.a_req = req; bus.a_we = we; bus.a_addr = AW'(addr); bus.a_wdata = d;
    endtask

    task automatic set_b(input bit req, input bit we, input int addr, input logic [7:0] d);
        bus.b_req = req; bus.b_we = we; bus.b_addr = AW'(addr); bus.b_wdata = d;
    endtask

    // One clock: check outputs at the negedge against the model, advance the
    // model, then return just after the next posedge for new stimulus.
    task automatic cycle();
        int win;
        @(negedge clk);
        m_ga = 0; m_gb = 0;
        if (rst) begin
            check("rst_a_gnt", bus.a_gnt, 0);
            check("rst_b_gnt", bus.b_gnt, 0);
            check("rst_we",    bus.ram_we, 0);
            m_run = 0; m_cnt = 0; m_last = 1; m_pa = 0; m_pb = 0; m_hold = 0;
        end else begin
            check("init_done", bus.init_done, m_run);
            check("a_rvalid",  bus.a_rvalid, m_pa);
            check("b_rvalid",  bus.b_rvalid, m_pb);
            if (m_pa) check("a_rdata", bus.a_rdata, m_da);
            if (m_pb) check("b_rdata", bus.b_rdata, m_db);
            if (!m_run) begin
                check("swp_a_gnt", bus.a_gnt, 0);
                check("swp_b_gnt", bus.b_gnt, 0);
                check("swp_we",    bus.ram_we, 1);
                check("swp_addr",  bus.ram_addr, m_cnt);
                check("swp_data",  bus.ram_data, IV);
                m_mem[m_cnt] = IV;
                m_hold = m_cnt;
                m_pa = 0; m_pb = 0;
                if (m_cnt == DEPTH - 1) m_run = 1;
                m_cnt++;
            end else begin
                if (bus.a_req && bus.b_req) win = (m_last == 1) ? 0 : 1;
                else if (bus.a_req)         win = 0;
                else if (bus.b_req)         win = 1;
                else                        win = -1;
                m_ga = (win == 0); m_gb = (win == 1);
                check("a_gnt", bus.a_gnt, m_ga);
                check("b_gnt", bus.b_gnt, m_gb);
                m_pa = 0; m_pb = 0;
                if (win < 0) begin
                    check("idle_we",   bus.ram_we, 0);
                    check("idle_addr", bus.ram_addr, m_hold);
                end else begin
                    bit         we   = (win == 0) ? bus.a_we : bus.b_we;
                    int         addr = (win == 0) ? int'(bus.a_addr) : int'(bus.b_addr);
                    logic [7:0] wd   = (win == 0) ? bus.a_wdata : bus.b_wdata;
                    check("ram_we",   bus.ram_we, we);
                    check("ram_addr", bus.ram_addr, addr);
                    if (we) begin
                        check("ram_data", bus.ram_data, wd);
                        m_mem[addr] = wd;
                    end else if (win == 0) begin
                        m_pa = 1; m_da = m_mem[addr];
                    end else begin
                        m_pb = 1; m_db = m_mem[addr];
                    end
                    m_hold = addr;
                    m_last = win;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_a(input int idle_pct);
        set_a(($urandom_range(99) >= idle_pct), $urandom_range(1), $urandom_range(DEPTH-1), 8'($urandom));
    endtask

    task automatic rand_b(input int idle_pct);
        set_b(($urandom_range(99) >= idle_pct), $urandom_range(1), $urandom_range(DEPTH-1), 8'($urandom));
    endtask

    initial begin
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        #1;

        // Sweep with A requesting throughout: no grant until RUN.
        rst = 1;
        set_a(1, 1, 3, 8'hAA);
        repeat (3) cycle();
        rst = 0;
        repeat (16) cycle();
        check("sweep_len_done", bus.init_done, 1);
        cycle();                                  // A's held write is granted now
        check("held_req_served", m_ga, 1);
        set_a(0, 0, 0, 0);

        // Write then read back on the very next cycle.
        set_a(1, 1, 5, 8'h01); cycle();
        set_a(1, 0, 5, 8'h00); cycle();
        set_a(0, 0, 0, 0);     cycle();           // a_rvalid with 1 expected here
        cycle();

        // B alone: four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            set_b(1, 0, i + 2, 8'h00);
            cycle();
        end
        set_b(0, 0, 0, 0);
        repeat (3) cycle();                       // idle: no writes

        // Random traffic; commands held until granted.
        for (int n = 0; n < 400; n++) begin
            cycle();
            if (!bus.a_req || m_ga) rand_a(30);
            if (!bus.b_req || m_gb) rand_b(30);
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        repeat (2) cycle();

        // Readback of every word with idle gaps.
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1, 0, i, 8'h00); cycle();
            set_a(0, 0, 0, 0);     cycle();
        end

        // Reset right after a granted read: the pending response is dropped.
        set_a(1, 0, 7, 8'h00); cycle();
        set_a(0, 0, 0, 0);
        rst = 1; cycle();
        rst = 0;

        // Reset again at sweep count 7: sweep restarts from address 0.
        repeat (7) cycle();
        rst = 1; cycle();
        rst = 0;

        // Both ports continuously requesting from the start of the sweep.
        rand_a(0); rand_b(0);
        repeat (16) cycle();
        cycle();
        check("first_after_rst_A", m_ga, 1);
        for (int n = 0; n < 40; n++) begin
            if (m_ga) rand_a(0);
            if (m_gb) rand_b(0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
